// File: rtl/lm32_dtlb_walker.sv
// lm32_dtlb_walker: hardware refill engine for the DTLB. On a miss it reads the
// L1 and L2 page-table entries over a Wishbone master port and then emits one
// DTLB update (vaddr/paddr pair) or a fault with its cause.
//
// Handshake: wb_cyc_o/wb_stb_o rise when an access starts and stay high with a
// stable wb_adr_o until wb_ack_i or wb_err_i is seen (or abort/timeout ends the
// walk); each access is a single read and cyc always drops after it completes.
module lm32_dtlb_walker #(
  parameter int unsigned page_size      = 4096,
  parameter int unsigned l1_bits        = 10,
  parameter int unsigned timeout_cycles = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        miss_req_i,
  input  logic [31:0] miss_vaddr_i,
  input  logic [31:0] ptbase_i,
  input  logic        abort_i,
  output logic [31:0] wb_adr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy_o,
  output logic        tlb_update_o,
  output logic [31:0] tlb_vaddr_o,
  output logic [31:0] tlb_paddr_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o,
  output logic [2:0]  dbg_state_o
);

  localparam int unsigned OB  = $clog2(page_size);
  localparam int unsigned L2B = 32 - OB - l1_bits;
  localparam int unsigned TW  = $clog2(timeout_cycles + 1);

  localparam logic [31:0]   PAGE_MASK = ~((32'd1 << OB) - 32'd1);
  localparam logic [31:0]   L2_MASK   = (32'd1 << L2B) - 32'd1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(timeout_cycles - 1);

  localparam logic [1:0] C_NONE    = 2'd0;
  localparam logic [1:0] C_INVALID = 2'd1;
  localparam logic [1:0] C_BUS     = 2'd2;
  localparam logic [1:0] C_TIMEOUT = 2'd3;

  // S_GAP is the single idle bus cycle between the L1 and L2 reads.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_GAP  = 3'd2,
    S_L2   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   vaddr_q, ptbase_q, pte_q;
  logic [31:0]   tlb_vaddr_q, tlb_paddr_q;
  logic [TW-1:0] tmo_q;
  logic [1:0]    cause_q, cause_d;
  logic          ld_req, ld_l1, ld_tlb, tmo_clr, tmo_inc;
  logic [31:0]   l1_adr, l2_adr;

  // Table addresses: base frame, index field, word offset (truncated to 32 bits).
  assign l1_adr = ((ptbase_q >> OB) << (l1_bits + 2)) | ((vaddr_q >> (32 - l1_bits)) << 2);
  assign l2_adr = ((pte_q >> OB) << (L2B + 2)) | (((vaddr_q >> OB) & L2_MASK) << 2);

  // State register plus walk context, timeout counter and held DTLB pair.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      vaddr_q     <= '0;
      ptbase_q    <= '0;
      pte_q       <= '0;
      tlb_vaddr_q <= '0;
      tlb_paddr_q <= '0;
      tmo_q       <= '0;
      cause_q     <= C_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (ld_req) begin
        vaddr_q  <= miss_vaddr_i;
        ptbase_q <= ptbase_i;
      end
      if (ld_l1) pte_q <= wb_dat_i;
      if (ld_tlb) begin
        tlb_vaddr_q <= vaddr_q & PAGE_MASK;
        tlb_paddr_q <= wb_dat_i & PAGE_MASK;
      end
      if (tmo_clr)      tmo_q <= '0;
      else if (tmo_inc) tmo_q <= tmo_q + TW'(1);
    end
  end

  // Next-state logic: abort beats err, err beats ack, ack beats timeout.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ld_req  = 1'b0;
    ld_l1   = 1'b0;
    ld_tlb  = 1'b0;
    tmo_clr = 1'b0;
    tmo_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (miss_req_i) begin
          state_d = S_L1;
          cause_d = C_NONE;
          ld_req  = 1'b1;
          tmo_clr = 1'b1;
        end
      end
      S_L1, S_L2: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (wb_err_i) begin
          state_d = S_DONE;
          cause_d = C_BUS;
        end else if (wb_ack_i) begin
          if (!wb_dat_i[0]) begin
            state_d = S_DONE;
            cause_d = C_INVALID;
          end else if (state_q == S_L1) begin
            state_d = S_GAP;
            ld_l1   = 1'b1;
          end else begin
            state_d = S_DONE;
            cause_d = C_NONE;
            ld_tlb  = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_DONE;
          cause_d = C_TIMEOUT;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_GAP: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_L2;
          tmo_clr = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and completion outputs decoded from the registered state only.
  always_comb begin
    wb_cyc_o      = 1'b0;
    wb_adr_o      = '0;
    done_o        = 1'b0;
    tlb_update_o  = 1'b0;
    fault_o       = 1'b0;
    fault_cause_o = C_NONE;
    case (state_q)
      S_L1: begin
        wb_cyc_o = 1'b1;
        wb_adr_o = l1_adr;
      end
      S_L2: begin
        wb_cyc_o = 1'b1;
        wb_adr_o = l2_adr;
      end
      S_DONE: begin
        done_o        = 1'b1;
        tlb_update_o  = (cause_q == C_NONE);
        fault_o       = (cause_q != C_NONE);
        fault_cause_o = cause_q;
      end
      default: ;
    endcase
  end

  assign wb_stb_o    = wb_cyc_o;
  assign busy_o      = (state_q != S_IDLE);
  assign tlb_vaddr_o = tlb_vaddr_q;
  assign tlb_paddr_o = tlb_paddr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lm32_dtlb_walker.sv
// tb_lm32_dtlb_walker: directed vectors, corner sequences and random walks for
// lm32_dtlb_walker, checked against a page-table reference model.
module tb_lm32_dtlb_walker;

  localparam logic [31:0] PMASK  = 32'hFFFF_F000;
  localparam int          TMO    = 1023;
  localparam int          BUDGET = 2200;
  localparam int          K_NONE = 0;
  localparam int          K_ERR  = 1;
  localparam int          K_STALL = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        miss_req_i = 1'b0;
  logic [31:0] miss_vaddr_i = '0;
  logic [31:0] ptbase_i = '0;
  logic        abort_i = 1'b0;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o, wb_stb_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        busy_o, tlb_update_o, done_o, fault_o;
  logic [31:0] tlb_vaddr_o, tlb_paddr_o;
  logic [1:0]  fault_cause_o;
  logic [2:0]  dbg_state_o;

  lm32_dtlb_walker #(.page_size(4096), .l1_bits(10), .timeout_cycles(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .miss_req_i(miss_req_i), .miss_vaddr_i(miss_vaddr_i),
    .ptbase_i(ptbase_i), .abort_i(abort_i), .wb_adr_o(wb_adr_o), .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .busy_o(busy_o), .tlb_update_o(tlb_update_o), .tlb_vaddr_o(tlb_vaddr_o),
    .tlb_paddr_o(tlb_paddr_o), .done_o(done_o), .fault_o(fault_o),
    .fault_cause_o(fault_cause_o), .dbg_state_o(dbg_state_o)
  );

  // Clock and reset.
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Page-table memory seen by the slave and by the reference model.
  logic [31:0] mem [logic [31:0]];

  // Slave knobs: wait states per access, and which access (1 or 2) misbehaves.
  int sl_delay = 1;
  int sl_bad_acc = 0;
  int sl_bad_kind = K_NONE;
  int s_acc = 0;

  typedef struct {
    int          acc;
    logic [31:0] l1_adr;
    logic [31:0] l2_adr;
    int          l2_start;
    int          done_cnt;
    int          done_cyc;
    logic        fault;
    logic [1:0]  cause;
    int          upd_cnt;
    logic [31:0] tlb_v;
    logic [31:0] tlb_p;
    int          end_cyc;
    int          bad;
  } res_t;

  typedef struct {
    logic [31:0] va;
    logic [31:0] pb;
    logic [31:0] l1pte;
    logic [31:0] l2pte;
    int          d;
    int          bad_acc;
    int          bad_kind;
    int          e_acc;
    logic [31:0] e_l1;
    logic [31:0] e_l2;
    int          e_done;
    logic [1:0]  e_cause;
    logic [31:0] e_tv;
    logic [31:0] e_tp;
  } vec_t;

  // Wishbone slave: ack (or err) arrives `sl_delay` cycles after cyc rises.
  initial begin
    int wcnt;
    bit in_acc;
    wcnt = 0;
    in_acc = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i || !wb_cyc_o || wb_ack_i || wb_err_i) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wcnt = 0;
        in_acc = 0;
      end else begin
        if (!in_acc) begin
          in_acc = 1;
          s_acc++;
        end
        wcnt++;
        if (wcnt > sl_delay) begin
          if (s_acc == sl_bad_acc && sl_bad_kind == K_STALL) begin
            wb_ack_i = 1'b0;
          end else if (s_acc == sl_bad_acc && sl_bad_kind == K_ERR) begin
            wb_err_i = 1'b1;
          end else begin
            wb_ack_i = 1'b1;
            wb_dat_i = mem.exists(wb_adr_o) ? mem[wb_adr_o] : 32'h0;
          end
        end
      end
    end
  end

  function automatic res_t blank();
    res_t r;
    r.acc = 0; r.l1_adr = '0; r.l2_adr = '0; r.l2_start = 0;
    r.done_cnt = 0; r.done_cyc = 0; r.fault = 1'b0; r.cause = 2'd0;
    r.upd_cnt = 0; r.tlb_v = '0; r.tlb_p = '0; r.end_cyc = 0; r.bad = 0;
    return r;
  endfunction

  // Reference model: walks the table in `mem`, counts cycles from the request
  // (cycle 0). An access starting at cycle t completes at t+d; a timeout ends
  // the walk at t+TMO; the L2 read starts two cycles after the L1 completion.
  function automatic res_t model(input logic [31:0] va, input logic [31:0] pb, input int d,
                                 input int bad_acc, input int bad_kind, input int abort_cyc,
                                 input logic [31:0] tv, input logic [31:0] tp);
    res_t        e;
    int          t;
    int          done_at;
    logic [1:0]  cause;
    logic [31:0] adr, pte, paddr;
    e = blank();
    e.tlb_v = tv;
    e.tlb_p = tp;
    e.l1_adr = (pb & PMASK) + (va / 32'd4194304) * 32'd4;
    t = 1;
    done_at = 0;
    cause = 2'd0;
    paddr = '0;
    for (int k = 1; k <= 2 && done_at == 0; k++) begin
      e.acc = k;
      if (k == 2) e.l2_start = t;
      adr = (k == 1) ? e.l1_adr : e.l2_adr;
      if (bad_acc == k && bad_kind == K_STALL) begin
        done_at = t + TMO;
        cause = 2'd3;
      end else if (bad_acc == k && bad_kind == K_ERR) begin
        done_at = t + d + 1;
        cause = 2'd2;
      end else begin
        pte = mem.exists(adr) ? mem[adr] : 32'h0;
        if (pte[0] == 1'b0) begin
          done_at = t + d + 1;
          cause = 2'd1;
        end else if (k == 1) begin
          e.l2_adr = (pte & PMASK) + ((va / 32'd4096) % 32'd1024) * 32'd4;
          t = t + d + 2;
        end else begin
          done_at = t + d + 1;
          paddr = pte & PMASK;
        end
      end
    end
    if (abort_cyc >= 1 && abort_cyc < done_at) begin
      e.end_cyc = abort_cyc + 1;
      if (e.acc == 2 && e.l2_start > abort_cyc) e.acc = 1;
    end else begin
      e.done_cnt = 1;
      e.done_cyc = done_at;
      e.fault = (cause != 2'd0);
      e.cause = cause;
      e.upd_cnt = (cause == 2'd0) ? 1 : 0;
      e.end_cyc = done_at + 1;
      if (cause == 2'd0) begin
        e.tlb_v = va & PMASK;
        e.tlb_p = paddr;
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Driver + monitor: issue one miss at a negedge, watch cycles 1..end.
  task automatic run_walk(input logic [31:0] va, input logic [31:0] pb, input int d,
                          input int bad_acc, input int bad_kind, input int abort_cyc,
                          input int req_cyc, output res_t r);
    logic prev_cyc;
    r = blank();
    sl_delay = d;
    sl_bad_acc = bad_acc;
    sl_bad_kind = bad_kind;
    s_acc = 0;
    prev_cyc = 1'b0;
    @(negedge clk_i);
    miss_vaddr_i = va;
    ptbase_i = pb;
    miss_req_i = 1'b1;
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk_i);
      miss_req_i = 1'b0;
      abort_i = 1'b0;
      miss_vaddr_i = $urandom;
      ptbase_i = $urandom;
      if (wb_cyc_o && !prev_cyc) begin
        r.acc++;
        if (r.acc == 1) r.l1_adr = wb_adr_o;
        else if (r.acc == 2) begin
          r.l2_adr = wb_adr_o;
          r.l2_start = n;
        end
      end
      prev_cyc = wb_cyc_o;
      if (wb_stb_o !== wb_cyc_o) r.bad++;
      if (wb_cyc_o && wb_adr_o[1:0] != 2'b00) r.bad++;
      if (wb_cyc_o && (done_o || !busy_o)) r.bad++;
      if (!done_o && (tlb_update_o || fault_o || fault_cause_o != 2'd0)) r.bad++;
      if (done_o) begin
        r.done_cnt++;
        r.done_cyc = n;
        r.fault = fault_o;
        r.cause = fault_cause_o;
      end
      if (tlb_update_o) r.upd_cnt++;
      if (!busy_o) begin
        r.end_cyc = n;
        r.tlb_v = tlb_vaddr_o;
        r.tlb_p = tlb_paddr_o;
        break;
      end
      if (n == abort_cyc) abort_i = 1'b1;
      if (n == req_cyc) miss_req_i = 1'b1;
    end
    miss_req_i = 1'b0;
    abort_i = 1'b0;
  endtask

  // Scoreboard comparison of one walk.
  task automatic compare(input string tag, input res_t r, input res_t e);
    chk({tag, ".accesses"}, r.acc, e.acc);
    chk({tag, ".l1_adr"}, r.l1_adr, e.l1_adr);
    if (e.acc == 2) begin
      chk({tag, ".l2_adr"}, r.l2_adr, e.l2_adr);
      chk({tag, ".l2_start"}, r.l2_start, e.l2_start);
    end
    chk({tag, ".done_cnt"}, r.done_cnt, e.done_cnt);
    if (e.done_cnt == 1) begin
      chk({tag, ".done_cyc"}, r.done_cyc, e.done_cyc);
      chk({tag, ".fault"}, r.fault, e.fault);
      chk({tag, ".cause"}, r.cause, e.cause);
    end
    chk({tag, ".upd_cnt"}, r.upd_cnt, e.upd_cnt);
    chk({tag, ".tlb_vaddr"}, r.tlb_v, e.tlb_v);
    chk({tag, ".tlb_paddr"}, r.tlb_p, e.tlb_p);
    chk({tag, ".end_cyc"}, r.end_cyc, e.end_cyc);
    chk({tag, ".protocol"}, r.bad, 0);
  endtask

  vec_t        vecs [10];
  logic [31:0] m_tv = '0;
  logic [31:0] m_tp = '0;

  initial begin
    res_t        r, e;
    logic [31:0] va, pb, l1a, l1pte, l2pte;
    int          d, bad_acc, bad_kind, abort_cyc, req_cyc, sel;

    //           va            pb            l1pte         l2pte         d  bacc bkind    acc l1            l2            done cause tlb_v         tlb_p
    vecs[0] = '{32'h4000_5123, 32'h0010_0000, 32'h0020_0001, 32'h8765_4001, 1, 0, K_NONE,  2, 32'h0010_0400, 32'h0020_0014, 6,    2'd0, 32'h4000_5000, 32'h8765_4000};
    vecs[1] = '{32'h4000_5123, 32'h0010_0000, 32'h0020_0000, 32'h8765_4001, 1, 0, K_NONE,  1, 32'h0010_0400, 32'h0,        3,    2'd1, 32'h4000_5000, 32'h8765_4000};
    vecs[2] = '{32'h4000_5123, 32'h0010_0000, 32'h0020_0001, 32'h8765_4001, 1, 2, K_ERR,   2, 32'h0010_0400, 32'h0020_0014, 6,    2'd2, 32'h4000_5000, 32'h8765_4000};
    vecs[3] = '{32'h4000_5123, 32'h0010_0000, 32'h0020_0001, 32'h8765_4000, 1, 0, K_NONE,  2, 32'h0010_0400, 32'h0020_0014, 6,    2'd1, 32'h4000_5000, 32'h8765_4000};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0030_0ABC, 32'hABCD_E0F1, 32'h1234_5FFF, 1, 0, K_NONE,  2, 32'h0030_0FFC, 32'hABCD_EFFC, 6,    2'd0, 32'hFFFF_F000, 32'h1234_5000};
    vecs[5] = '{32'h0000_0000, 32'hFFFF_F000, 32'h0000_0001, 32'h0000_1001, 1, 0, K_NONE,  2, 32'hFFFF_F000, 32'h0000_0000, 6,    2'd0, 32'h0000_0000, 32'h0000_1000};
    vecs[6] = '{32'h4000_5123, 32'h0010_0000, 32'h0020_0001, 32'h8765_4001, 1, 1, K_ERR,   1, 32'h0010_0400, 32'h0,        3,    2'd2, 32'h0000_0000, 32'h0000_1000};
    vecs[7] = '{32'h4000_5123, 32'h0010_0000, 32'h0020_0001, 32'h8765_4001, 3, 0, K_NONE,  2, 32'h0010_0400, 32'h0020_0014, 10,   2'd0, 32'h4000_5000, 32'h8765_4000};
    vecs[8] = '{32'h4000_5123, 32'h0010_0000, 32'h0020_0001, 32'h8765_4001, 1, 1, K_STALL, 1, 32'h0010_0400, 32'h0,        1024, 2'd3, 32'h4000_5000, 32'h8765_4000};
    vecs[9] = '{32'h4000_5123, 32'h0010_0000, 32'h0020_0001, 32'h8765_4001, 2, 2, K_STALL, 2, 32'h0010_0400, 32'h0020_0014, 1028, 2'd3, 32'h4000_5000, 32'h8765_4000};

    // Reset state.
    repeat (3) @(negedge clk_i);
    chk("rst.ctrl", {wb_cyc_o, wb_stb_o, busy_o, tlb_update_o, done_o, fault_o, fault_cause_o}, 0);
    chk("rst.adr", wb_adr_o, 0);
    chk("rst.tlb_vaddr", tlb_vaddr_o, 0);
    chk("rst.tlb_paddr", tlb_paddr_o, 0);
    rst_i = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      mem.delete();
      mem[vecs[i].e_l1] = vecs[i].l1pte;
      if (vecs[i].e_acc == 2) mem[vecs[i].e_l2] = vecs[i].l2pte;
      run_walk(vecs[i].va, vecs[i].pb, vecs[i].d, vecs[i].bad_acc, vecs[i].bad_kind, 0, 0, r);
      e = blank();
      e.acc = vecs[i].e_acc;
      e.l1_adr = vecs[i].e_l1;
      e.l2_adr = vecs[i].e_l2;
      e.l2_start = (vecs[i].e_acc == 2) ? 3 + vecs[i].d : 0;
      e.done_cnt = 1;
      e.done_cyc = vecs[i].e_done;
      e.fault = (vecs[i].e_cause != 2'd0);
      e.cause = vecs[i].e_cause;
      e.upd_cnt = (vecs[i].e_cause == 2'd0) ? 1 : 0;
      e.tlb_v = vecs[i].e_tv;
      e.tlb_p = vecs[i].e_tp;
      e.end_cyc = vecs[i].e_done + 1;
      compare($sformatf("vec%0d", i), r, e);
      m_tv = e.tlb_v;
      m_tp = e.tlb_p;
    end

    // Abort on the cycle of the L2 ack: nothing issues, walker idles next cycle.
    mem.delete();
    mem[32'h0010_0400] = 32'h0020_0001;
    mem[32'h0020_0014] = 32'h8765_4001;
    run_walk(32'h4000_5123, 32'h0010_0000, 1, 0, K_NONE, 5, 0, r);
    chk("abort_l2ack.done_cnt", r.done_cnt, 0);
    chk("abort_l2ack.upd_cnt", r.upd_cnt, 0);
    chk("abort_l2ack.end_cyc", r.end_cyc, 6);
    // A fresh miss is accepted afterwards; a second miss mid-walk is ignored.
    mem[32'h0010_0400] = 32'h0055_5001;
    mem[32'h0055_5014] = 32'hCAFE_B001;
    run_walk(32'h4000_5123, 32'h0010_0000, 1, 0, K_NONE, 0, 3, r);
    e = model(32'h4000_5123, 32'h0010_0000, 1, 0, K_NONE, 0, m_tv, m_tp);
    chk("after_abort.tlb_paddr", r.tlb_p, 32'hCAFE_B000);
    compare("after_abort", r, e);
    m_tv = e.tlb_v; m_tp = e.tlb_p;
    // Abort during the DONE cycle has no effect.
    run_walk(32'h4000_5FFF, 32'h0010_0000, 1, 0, K_NONE, 6, 0, r);
    e = model(32'h4000_5FFF, 32'h0010_0000, 1, 0, K_NONE, 6, m_tv, m_tp);
    compare("abort_done", r, e);
    m_tv = e.tlb_v; m_tp = e.tlb_p;

    // Asynchronous reset in the middle of an L1 access.
    sl_delay = 6; sl_bad_acc = 0; sl_bad_kind = K_NONE; s_acc = 0;
    @(negedge clk_i);
    miss_vaddr_i = 32'h4000_5123; ptbase_i = 32'h0010_0000; miss_req_i = 1'b1;
    @(negedge clk_i);
    miss_req_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid.cyc_before", wb_cyc_o, 1);
    #2 rst_i = 1'b1;
    #1;
    chk("rst_mid.ctrl", {wb_cyc_o, wb_stb_o, busy_o, tlb_update_o, done_o, fault_o, fault_cause_o}, 0);
    chk("rst_mid.adr", wb_adr_o, 0);
    chk("rst_mid.tlb_vaddr", tlb_vaddr_o, 0);
    chk("rst_mid.tlb_paddr", tlb_paddr_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    m_tv = '0; m_tp = '0;

    // Random walks against the reference model.
    for (int i = 0; i < 60; i++) begin
      va = $urandom;
      pb = $urandom;
      d = $urandom_range(1, 3);
      l1pte = $urandom;
      l1pte[0] = ($urandom_range(0, 7) != 0);
      l2pte = $urandom;
      l2pte[0] = ($urandom_range(0, 7) != 0);
      mem.delete();
      l1a = (pb & PMASK) + (va / 32'd4194304) * 32'd4;
      mem[l1a] = l1pte;
      mem[(l1pte & PMASK) + ((va / 32'd4096) % 32'd1024) * 32'd4] = l2pte;
      sel = $urandom_range(0, 29);
      bad_kind = (sel == 0) ? K_STALL : (sel <= 3) ? K_ERR : K_NONE;
      bad_acc = $urandom_range(1, 2);
      e = model(va, pb, d, bad_acc, bad_kind, 0, m_tv, m_tp);
      abort_cyc = ($urandom_range(0, 4) == 0) ? $urandom_range(1, e.done_cyc) : 0;
      e = model(va, pb, d, bad_acc, bad_kind, abort_cyc, m_tv, m_tp);
      req_cyc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, e.end_cyc - 1) : 0;
      run_walk(va, pb, d, bad_acc, bad_kind, abort_cyc, req_cyc, r);
      compare($sformatf("rnd%0d", i), r, e);
      m_tv = e.tlb_v;
      m_tp = e.tlb_p;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
